// File: rtl/fetch_pipe_stage_if.sv
// rtl/fetch_pipe_stage_if.sv - fetch-to-decode valid/ready bus carrying {PC, instruction}
interface fetch_pipe_stage_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface

// File: rtl/fetch_pipe_stage.sv
// rtl/fetch_pipe_stage.sv - IF/ID stage with 2-entry skid buffer, flush and kill counter
module fetch_pipe_stage #(
    parameter int              XLEN       = 32,
    parameter int              ILEN       = 32,
    parameter logic [ILEN-1:0] NOP_INSTR  = 32'h00000013,
    parameter int              KILL_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_pipe_stage_if.slave     bus,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  csr_flush,
    output logic [1:0]            occupancy,
    output logic [KILL_CNT_W-1:0] kill_cnt
);
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [KILL_CNT_W-1:0] KILL_MAX = {KILL_CNT_W{1'b1}};

    state_t            state_q, state_d;
    logic [XLEN-1:0]   main_pc_q, skid_pc_q;
    logic [ILEN-1:0]   main_instr_q, skid_instr_q;
    logic [KILL_CNT_W-1:0] kill_cnt_q;

    logic in_ready_w, out_valid_w;
    logic in_fire, out_fire, kill;
    logic load_main_in, load_main_skid, load_skid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_EMPTY;
        else     state_q <= state_d;
    end

    // Status decodes depend on registered state only
    always_comb begin
        in_ready_w  = (state_q != S_TWO);
        out_valid_w = (state_q != S_EMPTY);
        occupancy   = 2'd0;
        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_TWO:   occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    assign in_fire  = bus.in_valid & in_ready_w;
    assign out_fire = out_valid_w & bus.out_ready & ~stall;
    assign kill     = flush | csr_flush;

    // Next state and data-register load strobes
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (kill) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (in_fire) begin
                    load_main_in = 1'b1;
                    state_d      = S_ONE;
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = S_TWO;
                    end else if (out_fire) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_d        = S_ONE;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            if (load_main_in) begin
                main_pc_q    <= bus.in_pc;
                main_instr_q <= bus.in_instr;
            end else if (load_main_skid) begin
                main_pc_q    <= skid_pc_q;
                main_instr_q <= skid_instr_q;
            end
            if (load_skid) begin
                skid_pc_q    <= bus.in_pc;
                skid_instr_q <= bus.in_instr;
            end
        end
    end

    // Killed entries = held entries plus the input accepted in the flush cycle
    logic [1:0]            kill_add;
    logic [KILL_CNT_W+1:0] kill_sum;
    assign kill_add = occupancy + {1'b0, in_fire};
    assign kill_sum = {2'b00, kill_cnt_q} + {{KILL_CNT_W{1'b0}}, kill_add};

    always_ff @(posedge clk) begin
        if (rst || csr_flush) begin
            kill_cnt_q <= '0;
        end else if (flush) begin
            if (kill_sum > {2'b00, KILL_MAX}) kill_cnt_q <= KILL_MAX;
            else                              kill_cnt_q <= kill_sum[KILL_CNT_W-1:0];
        end
    end

    assign kill_cnt      = kill_cnt_q;
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_pc    = out_valid_w ? main_pc_q : '0;
    assign bus.out_instr = out_valid_w ? main_instr_q : NOP_INSTR;
endmodule
